// File: rtl/tablero_pkg.sv
// tablero_pkg: shared definitions for the turn-signal sequencer.
//   - state_e      : sequencer states (IDLE, LEFT, RIGHT, HAZ)
//   - TS_LEFT/RIGHT: t_signal request encodings (2'b00 / 2'b11 mean "none")
//   - LEFT_PAT/RIGHT_PAT: per-step lamp patterns for each 3-lamp side
//   - lamp_pattern(): 6-bit lamp word for a given state and step
package tablero_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    HAZ   = 2'd3
  } state_e;

  localparam logic [1:0] TS_LEFT  = 2'b10;
  localparam logic [1:0] TS_RIGHT = 2'b01;

  // Index = step. Left grows from bit3 (inner) outwards, right from bit2.
  localparam logic [3:0][2:0] LEFT_PAT  = {3'b111, 3'b011, 3'b001, 3'b000};
  localparam logic [3:0][2:0] RIGHT_PAT = {3'b111, 3'b110, 3'b100, 3'b000};

  localparam int unsigned STEP_W = 24;

  function automatic logic [5:0] lamp_pattern(input state_e st, input logic [1:0] step);
    logic [5:0] lamp;
    lamp = 6'b000000;
    case (st)
      LEFT:    lamp = {LEFT_PAT[step], 3'b000};
      RIGHT:   lamp = {3'b000, RIGHT_PAT[step]};
      HAZ:     lamp = {LEFT_PAT[step], RIGHT_PAT[step]};
      default: lamp = 6'b000000;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/turn_seq_if.sv
// turn_seq_if: driver-side inputs and lamp outputs of the turn sequencer.
//   on, t_signal[1:0], brake, hazard : control levels (master -> slave)
//   lamp_seq[5:0]                    : lamp drive, [5:3] left, [2:0] right
//   step_tick                        : one-cycle pulse per animation step
// "sequence" is a reserved word in SystemVerilog, so the lamp drive
// output is carried as lamp_seq.
interface turn_seq_if;
  logic       on;
  logic [1:0] t_signal;
  logic       brake;
  logic       hazard;
  logic [5:0] lamp_seq;
  logic       step_tick;

  modport master (
    output on, t_signal, brake, hazard,
    input  lamp_seq, step_tick
  );

  modport slave (
    input  on, t_signal, brake, hazard,
    output lamp_seq, step_tick
  );
endinterface

// File: rtl/turn_seq_step_timer.sv
// step_timer: animation-step prescaler.
//   clk, rst : clock and synchronous active-high reset
//   clear    : restart the step period (state change)
//   enable   : count while high; held at its start value otherwise
//   tick     : combinational, high on the last cycle of each step period
// Implemented as a down-counter from STEP_CYCLES-1 to 0; tick timing is
// identical to an up-counter running 0..STEP_CYCLES-1.
module step_timer
  import tablero_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 6750000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [STEP_W-1:0] TERM = STEP_W'(STEP_CYCLES - 1);

  logic [STEP_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear || !enable) begin
      cnt_d = TERM;
    end else if (cnt_q == '0) begin
      tick  = 1'b1;
      cnt_d = TERM;
    end else begin
      cnt_d = cnt_q - STEP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= TERM;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/turn_seq.sv
// turn_seq: turn / hazard lamp sequencer with 4-step sweep animation.
//   clk, rst : clock and synchronous active-high reset
//   bus      : turn_seq_if.slave (on, t_signal, brake, hazard in;
//              lamp_seq, step_tick out, both registered)
//   STEP_CYCLES : clk cycles per animation step (2 .. 2^24-1)
// Build option: define TURN_SEQ_BRAKE_OVERLAY_EN to light the
// non-animated side(s) solid while braking with ignition on; otherwise
// brake is ignored.
//
// state | meaning
// IDLE  | no animation, timer and step held at 0
// LEFT  | left side sweeps, right side off
// RIGHT | right side sweeps, left side off
// HAZ   | both sides sweep together from the shared step
module turn_seq
  import tablero_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 6750000
) (
  input  logic         clk,
  input  logic         rst,
  turn_seq_if.slave    bus
);

  state_e     state_q, state_d;
  logic [1:0] step_q, step_d;
  logic [5:0] lamp_q, lamp_d;
  logic       tick_q, tick_d;
  logic       state_chg;
  logic       timer_tick;

  step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_chg),
    .enable (state_q != IDLE),
    .tick   (timer_tick)
  );

  always_comb begin
    state_d = IDLE;
    if (bus.hazard)                   state_d = HAZ;
    else if (!bus.on)                 state_d = IDLE;
    else if (bus.t_signal == TS_LEFT)  state_d = LEFT;
    else if (bus.t_signal == TS_RIGHT) state_d = RIGHT;
    else                              state_d = IDLE;

    state_chg = (state_d != state_q);

    // A state change restarts the sweep; the timer is cleared in the
    // same cycle so the new state always gets a full first step.
    step_d = step_q;
    tick_d = 1'b0;
    if (state_chg) begin
      step_d = 2'd0;
    end else if (timer_tick) begin
      step_d = step_q + 2'd1;
      tick_d = 1'b1;
    end

    // Outputs are computed from next state/step so the lamps follow
    // the input change with exactly one clock of latency.
    lamp_d = lamp_pattern(state_d, step_d);

`ifdef TURN_SEQ_BRAKE_OVERLAY_EN
    if (bus.on && bus.brake) begin
      case (state_d)
        IDLE:    lamp_d = 6'b111111;
        LEFT:    lamp_d[2:0] = 3'b111;
        RIGHT:   lamp_d[5:3] = 3'b111;
        default: ;
      endcase
    end
`endif
  end

`ifndef TURN_SEQ_BRAKE_OVERLAY_EN
  logic unused_brake;
  assign unused_brake = bus.brake;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      lamp_q  <= 6'b000000;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      lamp_q  <= lamp_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.lamp_seq  = lamp_q;
  assign bus.step_tick = tick_q;

endmodule

// File: tb/tb_turn_seq.sv
module tb_turn_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

`ifdef TURN_SEQ_BRAKE_OVERLAY_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic [2:0] lp [4];
  logic [2:0] rp [4];

  turn_seq_if bus ();

  turn_seq #(.STEP_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic clk1;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    bus.on = 1'b0; bus.t_signal = 2'b00; bus.brake = 1'b0; bus.hazard = 1'b0;
    clk1();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [5:0] exp;
    int s;
    rst = 1'b1;
    bus.on = 1'b0; bus.t_signal = 2'b00; bus.brake = 1'b0; bus.hazard = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk1();
      checks++;
      if (bus.lamp_seq !== 6'b000000) begin
        errors++; $display("FAIL reset_hold_seq i=%0d got %b want 000000", i, bus.lamp_seq);
      end
      checks++;
      if (bus.step_tick !== 1'b0) begin
        errors++; $display("FAIL reset_hold_tick i=%0d got %b want 0", i, bus.step_tick);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      clk1();
      s = ((k - 1) / 4) % 4;
      exp = {lp[s], rp[s]};
      checks++;
      if (bus.lamp_seq !== exp) begin
        errors++; $display("FAIL reset_release_seq k=%0d got %b want %b", k, bus.lamp_seq, exp);
      end
      checks++;
      if (bus.step_tick !== (k > 1 && ((k - 1) % 4) == 0)) begin
        errors++; $display("FAIL reset_release_tick k=%0d got %b", k, bus.step_tick);
      end
    end
  endtask

  task automatic test_left;
    logic [5:0] exp;
    int s;
    apply_reset();
    bus.on = 1'b1; bus.t_signal = 2'b10;
    for (int k = 1; k <= 20; k++) begin
      clk1();
      s = ((k - 1) / 4) % 4;
      exp = {lp[s], 3'b000};
      checks++;
      if (bus.lamp_seq !== exp) begin
        errors++; $display("FAIL left_seq k=%0d got %b want %b", k, bus.lamp_seq, exp);
      end
      checks++;
      if (bus.step_tick !== (k > 1 && ((k - 1) % 4) == 0)) begin
        errors++; $display("FAIL left_tick k=%0d got %b", k, bus.step_tick);
      end
    end
  endtask

  task automatic test_switch;
    logic [5:0] exp;
    int s;
    apply_reset();
    bus.on = 1'b1; bus.t_signal = 2'b10;
    repeat (9) clk1();
    checks++;
    if (bus.lamp_seq !== 6'b011000) begin
      errors++; $display("FAIL switch_pre got %b want 011000", bus.lamp_seq);
    end
    bus.t_signal = 2'b01;
    for (int j = 0; j <= 12; j++) begin
      clk1();
      s = j / 4;
      exp = {3'b000, rp[s]};
      checks++;
      if (bus.lamp_seq !== exp) begin
        errors++; $display("FAIL switch_seq j=%0d got %b want %b", j, bus.lamp_seq, exp);
      end
      checks++;
      if (bus.step_tick !== (j > 0 && (j % 4) == 0)) begin
        errors++; $display("FAIL switch_tick j=%0d got %b", j, bus.step_tick);
      end
    end
  endtask

  task automatic test_disabled;
    logic [5:0] exp;
    int s;
    apply_reset();
    bus.on = 1'b0; bus.t_signal = 2'b10; bus.hazard = 1'b0;
    for (int i = 0; i < 12; i++) begin
      clk1();
      checks++;
      if (bus.lamp_seq !== 6'b000000 || bus.step_tick !== 1'b0) begin
        errors++; $display("FAIL off_idle i=%0d got seq=%b tick=%b want 000000/0", i, bus.lamp_seq, bus.step_tick);
      end
    end
    bus.hazard = 1'b1;
    for (int j = 0; j <= 4; j++) begin
      clk1();
      s = j / 4;
      exp = {lp[s], rp[s]};
      checks++;
      if (bus.lamp_seq !== exp) begin
        errors++; $display("FAIL off_haz_seq j=%0d got %b want %b", j, bus.lamp_seq, exp);
      end
      checks++;
      if (bus.step_tick !== (j == 4)) begin
        errors++; $display("FAIL off_haz_tick j=%0d got %b", j, bus.step_tick);
      end
    end
  endtask

  task automatic test_brake;
    logic [5:0] exp;
    logic [2:0] side;
    int s;
    apply_reset();
    side = OVL ? 3'b111 : 3'b000;
    bus.on = 1'b1; bus.t_signal = 2'b01; bus.brake = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      clk1();
      s = (k - 1) / 4;
      exp = {side, rp[s]};
      checks++;
      if (bus.lamp_seq !== exp) begin
        errors++; $display("FAIL brake_right k=%0d got %b want %b", k, bus.lamp_seq, exp);
      end
    end
    bus.t_signal = 2'b00;
    exp = {side, side};
    for (int i = 0; i < 3; i++) begin
      clk1();
      checks++;
      if (bus.lamp_seq !== exp || bus.step_tick !== 1'b0) begin
        errors++; $display("FAIL brake_idle i=%0d got seq=%b tick=%b want %b/0", i, bus.lamp_seq, bus.step_tick, exp);
      end
    end
    bus.hazard = 1'b1;
    clk1();
    checks++;
    if (bus.lamp_seq !== 6'b000000) begin
      errors++; $display("FAIL brake_haz got %b want 000000", bus.lamp_seq);
    end
    bus.brake = 1'b0; bus.hazard = 1'b0;
  endtask

  task automatic test_none_and_reset;
    logic [5:0] exp;
    int s;
    apply_reset();
    bus.on = 1'b1; bus.t_signal = 2'b11;
    for (int i = 0; i < 6; i++) begin
      clk1();
      checks++;
      if (bus.lamp_seq !== 6'b000000 || bus.step_tick !== 1'b0) begin
        errors++; $display("FAIL both_req_idle i=%0d got seq=%b tick=%b", i, bus.lamp_seq, bus.step_tick);
      end
    end
    bus.hazard = 1'b1;
    for (int j = 0; j <= 12; j++) begin
      clk1();
      s = j / 4;
      exp = {lp[s], rp[s]};
      checks++;
      if (bus.lamp_seq !== exp) begin
        errors++; $display("FAIL haz_run j=%0d got %b want %b", j, bus.lamp_seq, exp);
      end
    end
    rst = 1'b1;
    clk1();
    checks++;
    if (bus.lamp_seq !== 6'b000000 || bus.step_tick !== 1'b0) begin
      errors++; $display("FAIL reset_mid_haz got seq=%b tick=%b want 000000/0", bus.lamp_seq, bus.step_tick);
    end
    rst = 1'b0;
    for (int j = 0; j <= 4; j++) begin
      clk1();
      s = j / 4;
      exp = {lp[s], rp[s]};
      checks++;
      if (bus.lamp_seq !== exp) begin
        errors++; $display("FAIL haz_restart j=%0d got %b want %b", j, bus.lamp_seq, exp);
      end
      checks++;
      if (bus.step_tick !== (j == 4)) begin
        errors++; $display("FAIL haz_restart_tick j=%0d got %b", j, bus.step_tick);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    lp = '{3'b000, 3'b001, 3'b011, 3'b111};
    rp = '{3'b000, 3'b100, 3'b110, 3'b111};
    rst = 1'b1;
    bus.on = 1'b0; bus.t_signal = 2'b00; bus.brake = 1'b0; bus.hazard = 1'b0;
    #2;
    test_reset();
    test_left();
    test_switch();
    test_disabled();
    test_brake();
    test_none_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/turn_seq.md
TURN_SEQ -- requirements
Module: turn_seq

Interface
REQ-001 Parameter STEP_CYCLES, default 6750000, clk cycles per animation step (0.25 s at 27 MHz); legal range 2..2^24-1.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 on  input  1  ignition; 0 disables turn and brake lamps.
REQ-005 t_signal  input  2  turn request: 2'b10 left, 2'b01 right, 2'b00 and 2'b11 none.
REQ-006 brake  input  1  brake pedal level.
REQ-007 hazard  input  1  hazard switch level.
REQ-008 sequence  output  6  lamp drive: [5:3] left (bit3 inner, bit5 outer), [2:0] right (bit2 inner, bit0 outer); registered.
REQ-009 step_tick  output  1  one-cycle pulse on every animation step; registered.

Function
REQ-010 The FSM SHALL have states IDLE, LEFT, RIGHT, HAZ.
REQ-011 Next-state priority SHALL be: hazard=1 -> HAZ (regardless of on); else on=0 -> IDLE; else t_signal 2'b10 -> LEFT, 2'b01 -> RIGHT; else IDLE.
REQ-012 Each state change SHALL reset the prescaler and the step counter (2-bit, 0..3) to 0 in the same cycle.
REQ-013 Prescaler SHALL count 0..STEP_CYCLES-1; at terminal count, step_tick=1 for one cycle and step counter SHALL advance, wrapping 3->0.
REQ-014 In IDLE, prescaler and step counter SHALL be held at 0 and step_tick SHALL stay 0.
REQ-015 Active-side pattern by step: 0 -> all off, 1 -> inner, 2 -> inner+middle, 3 -> all three (left 000,001,011,111 on [5:3]; right 000,100,110,111 on [2:0]).
REQ-016 LEFT drives pattern on [5:3]; RIGHT on [2:0]; HAZ on both sides simultaneously from the shared step counter.
REQ-017 Non-animated side SHALL be 000 except when the brake overlay (REQ-024) applies.
REQ-018 sequence SHALL reflect the registered state/step one cycle after the input change that caused it (latency 1 clk).
REQ-019 Request change mid-sequence (e.g. LEFT->RIGHT at step 2) SHALL restart at step 0 of the new state; no partial pattern carried over.
REQ-020 Input glitches are not filtered; inputs are assumed synchronous to clk.

Reset
REQ-021 While rst=1: state IDLE, prescaler 0, step 0, sequence 6'b000000, step_tick 0.
REQ-022 rst SHALL override all inputs, including mid-sequence and hazard; first non-reset cycle evaluates REQ-011 normally.

Configuration
REQ-023 Macro TURN_SEQ_BRAKE_OVERLAY_EN selects brake overlay.
REQ-024 Defined: when on=1 and brake=1, any side not animated in the current state SHALL drive 111; animated sides keep their pattern; HAZ ignores brake.
REQ-025 Undefined: brake SHALL be ignored entirely (port kept, unused).

Structure
REQ-026 Shared package tablero_pkg SHALL hold the state enum (IDLE, LEFT, RIGHT, HAZ), the 4-entry left/right step pattern constants, and the t_signal encodings.
REQ-027 Prescaler SHALL be a sub-module step_timer (inputs clk, rst, clear, enable; output tick), parameterised by STEP_CYCLES.
REQ-028 FSM, step counter and output register SHALL live in turn_seq.

Verification (STEP_CYCLES=4)
REQ-029 rst held 3 cycles with hazard=1, then released -> sequence 000000 during reset; 000000 the first cycle after; 001100 (left inner + right inner) after 4 further clocks, step_tick pulsing every 4 clocks.
REQ-030 on=1, t_signal=2'b10 for 20 clocks -> sequence [5:3] cycles 000,001,011,111,000 with 4 clocks per step; [2:0] stays 000.
REQ-031 LEFT at step 2 (011000), switch t_signal=2'b01 -> next cycle 000000, then 000100, 000110, 000111 at 4-clock intervals.
REQ-032 on=0, t_signal=2'b10, hazard=0 -> sequence 000000 and step_tick 0 indefinitely; assert hazard=1 -> HAZ animation starts at step 0.
REQ-033 With TURN_SEQ_BRAKE_OVERLAY_EN: on=1, RIGHT, brake=1 -> [5:3]=111 while [2:0] animates; brake=1 in IDLE -> 111111; without macro same stimulus -> [5:3]=000 and 000000.
REQ-034 t_signal=2'b11, on=1 -> IDLE, sequence 000000; rst=1 asserted mid-HAZ at step 3 -> 000000 next cycle.
